// File: rtl/tile_instr_sequencer.sv
// Per-tile instruction sequencer: local program memory played out one word per cycle
// with pass repetition, stall and halt; drives a NOP whenever nothing is issued.
module tile_instr_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int LCW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [63:0]   load_data,
    input  logic          start,
    input  logic [AW:0]   prog_len,
    input  logic [LCW-1:0] loop_count,
    input  logic          stall,
    input  logic          halt,
    output logic [63:0]   instruction,
    output logic          instr_valid,
    output logic          busy,
    output logic          done
);

    localparam logic [63:0] NOP     = 64'h0000_0000_0000_0007;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [63:0]    r_mem [DEPTH];
    logic [AW-1:0]  r_pc, w_pc_nxt;
    logic [AW-1:0]  r_last, w_last_nxt;
    logic [LCW-1:0] r_pass, w_pass_nxt;
    logic [LCW-1:0] r_passes, w_passes_nxt;
    logic [63:0]    r_instr, w_instr_nxt;
    logic           r_vld, w_vld_nxt;
    logic           r_done, w_done_nxt;
    logic [AW:0]    w_len_clamped;
    logic [AW:0]    w_len_m1;
    logic [63:0]    w_mem_rd;

    assign w_len_clamped = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign w_len_m1      = w_len_clamped - 1'b1;
    assign w_mem_rd      = r_mem[r_pc];

    // Memory is writable only while idle; reset does not clear it.
    always_ff @(posedge clk) begin
        if (rst && load_en && (r_state == S_IDLE)) begin
            r_mem[load_addr] <= load_data;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_pass_nxt   = r_pass;
        w_last_nxt   = r_last;
        w_passes_nxt = r_passes;
        w_instr_nxt  = NOP;
        w_vld_nxt    = 1'b0;
        w_done_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (prog_len != '0) begin
                        w_last_nxt   = w_len_m1[AW-1:0];
                        w_passes_nxt = loop_count;
                        w_pc_nxt     = '0;
                        w_pass_nxt   = '0;
                        w_state_nxt  = S_RUN;
                    end else begin
                        w_state_nxt  = S_FINISH;
                    end
                end
            end
            S_RUN: begin
                if (halt) begin
                    w_state_nxt = S_IDLE;
                end else if (!stall) begin
                    w_instr_nxt = w_mem_rd;
                    w_vld_nxt   = 1'b1;
                    if (r_pc == r_last) begin
                        // End of a pass: wrap immediately so passes run back-to-back.
                        w_pc_nxt   = '0;
                        w_pass_nxt = r_pass + 1'b1;
                        if (r_pass == r_passes) begin
                            w_state_nxt = S_FINISH;
                        end
                    end else begin
                        w_pc_nxt = r_pc + 1'b1;
                    end
                end
            end
            S_FINISH: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_pass  <= '0;
            r_instr <= NOP;
            r_vld   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_pass  <= w_pass_nxt;
            r_instr <= w_instr_nxt;
            r_vld   <= w_vld_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Program bounds are only meaningful in RUN, so they need no reset.
    always_ff @(posedge clk) begin
        r_last   <= w_last_nxt;
        r_passes <= w_passes_nxt;
    end

    assign instruction = r_instr;
    assign instr_valid = r_vld;
    assign busy        = (r_state == S_RUN);
    assign done        = r_done;

endmodule

// File: tb/tb_tile_instr_sequencer.sv
// Scoreboard bench for tile_instr_sequencer: stimulus queues cycle-stamped expected
// outputs, a negedge monitor pops and compares on every valid word or done pulse.
module tb_tile_instr_sequencer;

    localparam logic [63:0] NOP = 64'h0000_0000_0000_0007;

    typedef struct {
        int          cyc;
        logic [63:0] instr;
        logic        vld;
        logic        dn;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [63:0] load_data;
    logic        start;
    logic [4:0]  prog_len;
    logic [7:0]  loop_count;
    logic        stall;
    logic        halt;
    logic [63:0] instruction;
    logic        instr_valid;
    logic        busy;
    logic        done;

    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    exp_t        q[$];
    logic [63:0] mmem [16];

    tile_instr_sequencer #(.DEPTH(16), .AW(4), .LCW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .start      (start),
        .prog_len   (prog_len),
        .loop_count (loop_count),
        .stall      (stall),
        .halt       (halt),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every valid word or done pulse must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (instr_valid || done) begin
            n_tests = n_tests + 1;
            if (q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL unexpected_output cyc=%0d instr=%h vld=%0b done=%0b required=no output",
                         cyc, instruction, instr_valid, done);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || e.instr != instruction || e.vld != instr_valid || e.dn != done) begin
                    n_fail = n_fail + 1;
                    $display("FAIL sb_output got cyc=%0d instr=%h vld=%0b done=%0b required cyc=%0d instr=%h vld=%0b done=%0b",
                             cyc, instruction, instr_valid, done, e.cyc, e.instr, e.vld, e.dn);
                end
            end
        end
    end

    function automatic void push(input int c, input logic [63:0] d, input logic v, input logic dn);
        exp_t e;
        e.cyc   = c;
        e.instr = d;
        e.vld   = v;
        e.dn    = dn;
        q.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        n_tests = n_tests + 1;
        if (got !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic load(input int a, input logic [63:0] d);
        load_en   = 1'b1;
        load_addr = 4'(a);
        load_data = d;
        @(negedge clk);
        load_en   = 1'b0;
        mmem[a]   = d;
    endtask

    // Unstalled playback; optionally drives a write to mem[1] throughout RUN.
    task automatic play(input int plen, input int lc, input bit ld_run);
        int k, len, n, bcnt;
        k    = cyc;
        len  = (plen > 16) ? 16 : plen;
        n    = len * (lc + 1);
        for (int i = 0; i < n; i++) push(k + 2 + i, mmem[i % len], 1'b1, 1'b0);
        push(k + 2 + n, NOP, 1'b0, 1'b1);
        prog_len   = 5'(plen);
        loop_count = 8'(lc);
        start      = 1'b1;
        bcnt       = 0;
        for (int j = 1; j <= n + 3; j++) begin
            @(negedge clk);
            if (j == 1) begin
                start = 1'b0;
                if (ld_run) begin
                    load_en   = 1'b1;
                    load_addr = 4'd1;
                    load_data = 64'hFF;
                end
            end
            if (j == n + 1) load_en = 1'b0;
            bcnt += int'(busy);
        end
        chk("busy_cycles", 64'(bcnt), 64'(n));
        chk("idle_nop", instruction, NOP);
    endtask

    initial begin
        int k;
        rst = 1'b0; start = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        prog_len = 5'd3; loop_count = '0; stall = 1'b0; halt = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_instr", instruction, NOP);
        chk("rst_vld", 64'(instr_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_instr", instruction, NOP);

        load(0, 64'hA0); load(1, 64'hA1); load(2, 64'hA2);
        for (int i = 3; i < 16; i++) load(i, 64'hB0 + 64'(i));

        play(3, 0, 1'b0);            // basic
        play(3, 2, 1'b0);            // three passes, no bubbles

        // Stall one cycle after A0 issues
        k = cyc;
        push(k + 2, 64'hA0, 1'b1, 1'b0);
        push(k + 4, 64'hA1, 1'b1, 1'b0);
        push(k + 5, 64'hA2, 1'b1, 1'b0);
        push(k + 6, NOP,    1'b0, 1'b1);
        prog_len = 5'd3; loop_count = 8'd0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); stall = 1'b1;
        @(negedge clk); stall = 1'b0;
        chk("stall_vld", 64'(instr_valid), 64'd0);
        chk("stall_instr", instruction, NOP);
        chk("stall_busy", 64'(busy), 64'd1);
        repeat (4) @(negedge clk);

        // Halt after the fifth issue of a 16-word program
        k = cyc;
        for (int i = 0; i < 5; i++) push(k + 2 + i, mmem[i], 1'b1, 1'b0);
        prog_len = 5'd16; loop_count = 8'd0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        halt = 1'b1;
        @(negedge clk); halt = 1'b0;
        chk("halt_vld", 64'(instr_valid), 64'd0);
        chk("halt_instr", instruction, NOP);
        chk("halt_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        play(2, 0, 1'b0);            // replay from mem[0]

        play(0, 0, 1'b0);            // empty program: done only
        play(3, 0, 1'b1);            // write attempt during RUN
        play(3, 0, 1'b0);            // mem[1] still A1
        play(20, 0, 1'b0);           // clamped to 16, pc wraps
        play(1, 255, 1'b0);          // 256 passes

        // Synchronous reset mid-run
        k = cyc;
        for (int i = 0; i < 3; i++) push(k + 2 + i, mmem[i], 1'b1, 1'b0);
        prog_len = 5'd16; loop_count = 8'd0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_instr", instruction, NOP);
        chk("midrst_vld", 64'(instr_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_idle", 64'(busy), 64'd0);
        play(3, 0, 1'b0);

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tile_instr_sequencer.md
Name: tile_instr_sequencer

Overview:
Per-tile instruction sequencer that sits directly upstream of the CGRA tile and drives its 64-bit instruction input. It holds a small local program memory, loaded by the configuration controller while idle. On start it plays the program out one instruction per cycle, with pass repetition, stall and halt control. Whenever it is not issuing, it drives a NOP (opcode 3'b111, reset bit [61] = 0), so the tile holds its state.

Parameters:
DEPTH, 16, number of 64-bit program memory entries
AW, 4, program address width, log2(DEPTH)
LCW, 8, loop count width

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset)
load_en  input  1  program memory write strobe
load_addr  input  AW  program memory write address
load_data  input  64  instruction word to write
start  input  1  begin playback (single-cycle pulse or level; sampled only in IDLE)
prog_len  input  AW+1  number of instructions per pass, sampled at start
loop_count  input  LCW  extra passes; total passes = loop_count+1, sampled at start
stall  input  1  hold issue this cycle
halt  input  1  abort playback
instruction  output  64  instruction to the tile, registered
instr_valid  output  1  instruction holds a program word (not filler NOP)
busy  output  1  high in RUN
done  output  1  one-cycle pulse on normal completion

Behaviour:
- NOP constant = 64'h0000_0000_0000_0007.
- Reset (rst==0 at clk edge):
  - state = IDLE; pc = 0; pass counter = 0.
  - instruction = NOP; instr_valid = 0; busy = 0; done = 0.
  - Program memory contents are not cleared.
  - Reset overrides every other input, including mid-RUN.
- States: IDLE, RUN, FINISH.
- IDLE:
  - load_en=1 writes mem[load_addr] <= load_data.
  - start=1 with prog_len>0 latches len = min(prog_len, DEPTH) and passes = loop_count, sets pc=0 and pass=0, then goes to RUN (busy=1 from the next cycle).
  - start=1 with prog_len==0 goes to FINISH. No instructions are issued.
  - If load_en and start are asserted in the same cycle, the write completes and playback starts; the written word is visible to playback.
- RUN:
  - load_en is ignored.
  - Each edge with stall=0: instruction <= mem[pc]; instr_valid <= 1.
    - If pc == len-1: pc <= 0 and pass increments.
    - If pc == len-1 and pass == passes: this is the last issue, and state <= FINISH.
  - Each edge with stall=1: instruction <= NOP; instr_valid <= 0; pc and pass hold.
  - halt=1 (priority over stall and issue): instruction <= NOP; instr_valid <= 0; state <= IDLE; done stays 0.
- FINISH, held one cycle:
  - instruction <= NOP; instr_valid <= 0; busy <= 0; done <= 1 for exactly one cycle; then IDLE with done <= 0.
  - start is ignored in FINISH.
- Latency:
  - start sampled at edge E0; mem[0] appears on instruction after edge E1 if stall=0 at E1.
  - An unstalled program issues exactly len*(loop_count+1) consecutive valid words, with no bubbles between passes.
  - done is asserted after the edge that follows the last issue.
- Counters:
  - pc is AW bits.
  - prog_len == DEPTH (value 16) is legal; pc wraps 15 -> 0.
  - prog_len > DEPTH is clamped to DEPTH.
  - pass counter is LCW bits; loop_count = 255 yields 256 passes without overflow.
- busy is high exactly while state == RUN.

Test Plan:
- Reset: drive rst=0 for 2 cycles with start=1 -> instruction=64'h7, instr_valid=0, busy=0, done=0; then release rst -> still IDLE.
- Basic playback: load mem[0..2] = 64'hA0, 64'hA1, 64'hA2; prog_len=3, loop_count=0; pulse start -> A0, A1, A2 on three consecutive cycles with instr_valid=1; then NOP with done=1 for one cycle; busy high for exactly 3 cycles.
- Looping: same program, loop_count=2 -> nine consecutive valid words A0 A1 A2 A0 A1 A2 A0 A1 A2, then a single done pulse.
- Stall: prog_len=3; stall=1 in the cycle after A0 issues -> sequence A0, NOP (instr_valid=0), A1, A2; done delayed by one cycle.
- Halt mid-run: prog_len=16, halt=1 after the 5th issue -> NOP next cycle, busy=0, done never asserted; a later start replays from mem[0].
- Edge cases:
  - prog_len=0 -> no valid words; done pulses one cycle after start.
  - load_en during RUN with load_addr=1, load_data=64'hFF -> memory unchanged, so a second run still issues A1.
  - Synchronous reset asserted mid-RUN -> NOP, idle state on the next edge.
